// File: rtl/branch_pkg.sv
// Shared branch/PC definitions: funct3 codes, FSM states, default reset vector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pcState_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/branch_pc_unit_if.sv
// Decode/comparator/fetch-side signal bundle of the PC unit; stats ports need BRANCH_STATS_EN.
// Latency: n/a (wiring only).
// Backpressure: stall travels master -> slave.
interface branch_pc_unit_if #(
  parameter int WIDTH_DATA_LENGTH = 32
);
  logic                         stall;
  logic                         instr_valid;
  logic                         is_branch;
  logic                         is_jal;
  logic                         is_jalr;
  logic [2:0]                   funct3;
  logic [WIDTH_DATA_LENGTH-1:0] imm;
  logic [WIDTH_DATA_LENGTH-1:0] rs1;
  logic                         BrEq;
  logic                         BrLT;
  logic                         BrUn;
  logic [WIDTH_DATA_LENGTH-1:0] pc;
  logic [WIDTH_DATA_LENGTH-1:0] pc_plus4;
  logic                         taken;
  logic                         trap;
  logic [WIDTH_DATA_LENGTH-1:0] trap_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0]                  br_count;
  logic [31:0]                  br_taken_count;
`endif

  modport master (
    output stall, instr_valid, is_branch, is_jal, is_jalr, funct3, imm, rs1, BrEq, BrLT,
    input  BrUn, pc, pc_plus4, taken, trap, trap_pc
`ifdef BRANCH_STATS_EN
    , input br_count, br_taken_count
`endif
  );

  modport slave (
    input  stall, instr_valid, is_branch, is_jal, is_jalr, funct3, imm, rs1, BrEq, BrLT,
    output BrUn, pc, pc_plus4, taken, trap, trap_pc
`ifdef BRANCH_STATS_EN
    , output br_count, br_taken_count
`endif
  );

endinterface

// File: rtl/branch_cond.sv
// Decodes branch funct3 into comparator mode and the taken condition.
// Latency: combinational. Backpressure: none.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       BrLT,
  output logic       BrUn,
  output logic       cond,
  output logic       illegal_funct3
);

  always_comb begin
    BrUn           = (funct3 == BLTU) || (funct3 == BGEU);
    cond           = 1'b0;
    illegal_funct3 = 1'b0;
    case (funct3)
      BEQ:       cond = BrEq;
      BNE:       cond = !BrEq;
      BLT, BLTU: cond = BrLT;
      BGE, BGEU: cond = !BrLT;
      default:   illegal_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// PC register + branch/JAL/JALR resolution with sticky trap; counters with BRANCH_STATS_EN.
// Latency: taken/BrUn/pc_plus4 combinational, pc/trap registered (1 cycle).
// Backpressure: stall freezes pc, trap and counters; BOOT->RUN ignores stall.
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter int                           WIDTH_DATA_LENGTH = 32,
  parameter logic [WIDTH_DATA_LENGTH-1:0] RESET_VECTOR      = WIDTH_DATA_LENGTH'(DEFAULT_RESET_VECTOR)
) (
  input logic              clk,
  input logic              rst,
  branch_pc_unit_if.slave  bus
);

  localparam int W = WIDTH_DATA_LENGTH;

  pcState_t     state, stateNext;
  logic [W-1:0] pcQ, trapPcQ, pcPlus4, target;
  logic         cond, illegalFunct3, brUn;
  logic         takenC, commit, fault, multiCtrl;

  branch_cond uCond (
    .funct3         (bus.funct3),
    .BrEq           (bus.BrEq),
    .BrLT           (bus.BrLT),
    .BrUn           (brUn),
    .cond           (cond),
    .illegal_funct3 (illegalFunct3)
  );

  assign pcPlus4   = pcQ + W'(4);
  assign target    = bus.is_jalr ? ((bus.rs1 + bus.imm) & ~W'(1)) : (pcQ + bus.imm);
  assign multiCtrl = (bus.is_branch & bus.is_jal) | (bus.is_branch & bus.is_jalr) |
                     (bus.is_jal & bus.is_jalr);

  always_comb begin
    stateNext = state;
    takenC    = 1'b0;
    commit    = 1'b0;
    fault     = 1'b0;
    case (state)
      BOOT: stateNext = RUN;
      RUN: begin
        takenC = bus.instr_valid & ((bus.is_branch & cond) | bus.is_jal | bus.is_jalr);
        commit = bus.instr_valid & !bus.stall;
        fault  = commit & ((takenC & (target[1:0] != 2'b00)) |
                           (bus.is_branch & illegalFunct3) | multiCtrl);
        if (fault) stateNext = HALT;
      end
      HALT:    stateNext = HALT;
      default: stateNext = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOOT;
      pcQ     <= RESET_VECTOR;
      trapPcQ <= '0;
    end else begin
      state <= stateNext;
      if (commit && !fault) pcQ <= takenC ? target : pcPlus4;
      // The faulting instruction's own PC is kept; pc itself stays on it.
      if (fault) trapPcQ <= pcQ;
    end
  end

  assign bus.BrUn     = brUn;
  assign bus.pc       = pcQ;
  assign bus.pc_plus4 = pcPlus4;
  assign bus.taken    = takenC;
  assign bus.trap     = (state == HALT);
  assign bus.trap_pc  = trapPcQ;

`ifdef BRANCH_STATS_EN
  logic [31:0] brCount, brTakenCount;

  always_ff @(posedge clk) begin
    if (rst) begin
      brCount      <= '0;
      brTakenCount <= '0;
    end else if (commit && !fault && bus.is_branch) begin
      if (brCount != 32'hFFFF_FFFF) brCount <= brCount + 32'd1;
      if (takenC && brTakenCount != 32'hFFFF_FFFF) brTakenCount <= brTakenCount + 32'd1;
    end
  end

  assign bus.br_count       = brCount;
  assign bus.br_taken_count = brTakenCount;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: directed scenarios then random traffic vs. an operand-level model.
// Stats ports are checked when BRANCH_STATS_EN is defined.
module tb_branch_pc_unit;
  import branch_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_pc_unit_if #(.WIDTH_DATA_LENGTH(W)) bus ();

  branch_pc_unit #(.WIDTH_DATA_LENGTH(W), .RESET_VECTOR(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The bench plays the comparator on raw operands.
  logic [31:0] opA, opB;
  assign bus.BrEq = (opA == opB);
  assign bus.BrLT = bus.BrUn ? (opA < opB) : ($signed(opA) < $signed(opB));

  typedef struct {
    logic        taken, brUn, trap;
    logic [31:0] pc, pcPlus4, trapPc, brCnt, brTakenCnt;
  } exp_t;

  exp_t sb[$];
  int   nTests = 0;
  int   nFail  = 0;

  logic [31:0] mPc, mTrapPc, mBr, mBrTaken;
  bit          mBoot, mHalted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nTests++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("taken",    {31'b0, bus.taken}, {31'b0, e.taken});
      check("BrUn",     {31'b0, bus.BrUn},  {31'b0, e.brUn});
      check("trap",     {31'b0, bus.trap},  {31'b0, e.trap});
      check("pc",       bus.pc,       e.pc);
      check("pc_plus4", bus.pc_plus4, e.pcPlus4);
      check("trap_pc",  bus.trap_pc,  e.trapPc);
`ifdef BRANCH_STATS_EN
      check("br_count",       bus.br_count,       e.brCnt);
      check("br_taken_count", bus.br_taken_count, e.brTakenCnt);
`endif
    end
  end

  // One cycle: drive, predict this cycle's outputs, advance the model, wait for the edge.
  task automatic step(input bit r, input bit st, input bit v, input bit b, input bit j,
                      input bit jr, input logic [2:0] f3, input logic [31:0] im,
                      input logic [31:0] base, input logic [31:0] a, input logic [31:0] bb);
    exp_t        e;
    bit          c, run, tk, commit, bad;
    logic [31:0] tgt;
    rst = r; bus.stall = st; bus.instr_valid = v; bus.is_branch = b; bus.is_jal = j;
    bus.is_jalr = jr; bus.funct3 = f3; bus.imm = im; bus.rs1 = base; opA = a; opB = bb;
    case (f3)
      3'd0:    c = (a == bb);
      3'd1:    c = (a != bb);
      3'd4:    c = ($signed(a) <  $signed(bb));
      3'd5:    c = ($signed(a) >= $signed(bb));
      3'd6:    c = (a <  bb);
      3'd7:    c = (a >= bb);
      default: c = 1'b0;
    endcase
    run    = !mBoot && !mHalted;
    tk     = run && v && ((b && c) || j || jr);
    tgt    = jr ? ((base + im) & 32'hFFFF_FFFE) : (mPc + im);
    commit = run && v && !st;
    bad    = commit && ((tk && (tgt % 4 != 0)) || (b && (f3 == 3'd2 || f3 == 3'd3)) ||
                        (int'(b) + int'(j) + int'(jr) > 1));
    e.taken = tk; e.brUn = (f3 == 3'd6 || f3 == 3'd7); e.trap = mHalted;
    e.pc = mPc; e.pcPlus4 = mPc + 32'd4; e.trapPc = mTrapPc;
    e.brCnt = mBr; e.brTakenCnt = mBrTaken;
    sb.push_back(e);
    if (r) begin
      mPc = 32'h0; mTrapPc = 32'h0; mBr = 0; mBrTaken = 0; mBoot = 1; mHalted = 0;
    end else if (mBoot) begin
      mBoot = 0;
    end else if (commit) begin
      if (bad) begin
        mHalted = 1; mTrapPc = mPc;
      end else begin
        if (b) begin
          if (mBr != 32'hFFFF_FFFF) mBr++;
          if (tk && mBrTaken != 32'hFFFF_FFFF) mBrTaken++;
        end
        mPc = tk ? tgt : mPc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    step(0, 0, 1, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic jalTo(input logic [31:0] dest);
    step(0, 0, 1, 0, 1, 0, 3'd0, dest - mPc, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic br(input logic [2:0] f3, input logic [31:0] im,
                    input logic [31:0] a, input logic [31:0] bb);
    step(0, 0, 1, 1, 0, 0, f3, im, 32'h0, a, bb);
  endtask

  logic [31:0] opVals [4];

  initial begin
    opVals[0] = 32'h0; opVals[1] = 32'h1; opVals[2] = 32'hFFFF_FFFF; opVals[3] = 32'h8000_0000;
    rst = 1; bus.stall = 0; bus.instr_valid = 0; bus.is_branch = 0; bus.is_jal = 0;
    bus.is_jalr = 0; bus.funct3 = 0; bus.imm = 0; bus.rs1 = 0; opA = 0; opB = 0;
    mPc = 0; mTrapPc = 0; mBr = 0; mBrTaken = 0; mBoot = 1; mHalted = 0;
    repeat (2) @(posedge clk);
    #1;
    // Boot, RUN entry, sequential fetch.
    nop(); nop(); nop(); nop();
    // BEQ taken / not taken from 0x100.
    jalTo(32'h100); br(BEQ, 32'h20, 32'h5, 32'h5);
    jalTo(32'h100); br(BEQ, 32'h20, 32'h5, 32'h6);
    // BLTU taken backwards, BLTU vs BLT on a negative operand.
    jalTo(32'h40); br(BLTU, 32'hFFFF_FFF8, 32'h1, 32'h2);
    br(BLTU, 32'h40, 32'hFFFF_FFFF, 32'h1);
    br(BLT, 32'h10, 32'hFFFF_FFFF, 32'h1);
    // JAL held by stall for three cycles.
    repeat (3) step(0, 1, 1, 0, 1, 0, 3'd0, 32'h10, 32'h0, 32'h0, 32'h0);
    step(0, 0, 1, 0, 1, 0, 3'd0, 32'h10, 32'h0, 32'h0, 32'h0);
    // Wrap from the top of the address space.
    jalTo(32'hFFFF_FFFC); nop(); nop();
    // Misaligned JALR: no trap while stalled, then sticky trap.
    step(0, 1, 1, 0, 0, 1, 3'd0, 32'h0, 32'h203, 32'h0, 32'h0);
    step(0, 0, 1, 0, 0, 1, 3'd0, 32'h0, 32'h203, 32'h0, 32'h0);
    nop(); jalTo(32'h80); nop();
    // Reset wins over stall and over a would-be fault.
    step(1, 1, 1, 0, 0, 1, 3'd0, 32'h0, 32'h203, 32'h0, 32'h0);
    nop(); nop();
    // Five branches, three taken, then a JAL.
    br(BEQ, 32'h8, 32'h1, 32'h1); br(BNE, 32'h8, 32'h1, 32'h1); br(BGE, 32'h8, 32'h3, 32'h2);
    br(BGEU, 32'h8, 32'h1, 32'h2); br(BLT, 32'h8, 32'h8000_0000, 32'h0);
    jalTo(32'h200); nop();
    // Illegal funct3 and two control kinds at once both trap.
    br(3'd2, 32'h8, 32'h0, 32'h0); nop();
    step(1, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    nop(); nop();
    step(0, 0, 1, 0, 1, 1, 3'd0, 32'h8, 32'h8, 32'h0, 32'h0); nop();
    step(1, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          r, st, v, b, j, jr;
      int          kind;
      logic [2:0]  f3;
      logic [31:0] im, base;
      r    = ($urandom_range(0, 199) == 0) || (mHalted && $urandom_range(0, 7) == 0);
      st   = ($urandom_range(0, 3) == 0);
      v    = ($urandom_range(0, 4) != 0);
      kind = $urandom_range(0, 9);
      b    = (kind >= 5 && kind <= 7);
      j    = (kind == 8);
      jr   = (kind == 9);
      if ($urandom_range(0, 49) == 0) b = 1;
      f3   = 3'($urandom_range(0, 7));
      if ((f3 == 3'd2 || f3 == 3'd3) && $urandom_range(0, 9) != 0) f3 = BEQ;
      im   = 32'(($urandom_range(0, 255) - 128) * 4);
      if ($urandom_range(0, 19) == 0) im = im | 32'($urandom_range(1, 3));
      base = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) base = base | 32'($urandom_range(1, 3));
      step(r, st, v, b, j, jr, f3, im, base, opVals[$urandom_range(0, 3)],
           opVals[$urandom_range(0, 3)]);
    end
    repeat (2) @(posedge clk);
    nTests++;
    if (sb.size() != 0) begin
      nFail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-resolution stage for the single-cycle RISC-V core. Drives `BrUn` into the branch comparator from the branch `funct3`, consumes the returned `BrEq`/`BrLT`, and resolves B-type, JAL and JALR control flow. Holds the architectural PC register and enters a sticky trap state on a misaligned or malformed control transfer. Sits between decode/register-file read and instruction fetch.

## Interface
Parameters:
- `WIDTH_DATA_LENGTH`, 32: PC and operand width.
- `RESET_VECTOR`, 32'h0000_0000: PC value loaded by reset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `stall`  in  1  freezes all state when high.
- `instr_valid`  in  1  current instruction is real (0 = bubble).
- `is_branch`  in  1  B-type instruction.
- `is_jal`  in  1  JAL instruction.
- `is_jalr`  in  1  JALR instruction.
- `funct3`  in  3  branch condition code.
- `imm`  in  WIDTH_DATA_LENGTH  sign-extended immediate.
- `rs1`  in  WIDTH_DATA_LENGTH  rs1 value (JALR base).
- `BrEq`  in  1  comparator equal flag.
- `BrLT`  in  1  comparator less-than flag.
- `BrUn`  out  1  unsigned-compare select to the comparator.
- `pc`  out  WIDTH_DATA_LENGTH  current PC (registered).
- `pc_plus4`  out  WIDTH_DATA_LENGTH  pc + 4 (link value).
- `taken`  out  1  control transfer redirects this cycle.
- `trap`  out  1  sticky fault flag (registered).
- `trap_pc`  out  WIDTH_DATA_LENGTH  PC of faulting instruction.
- `br_count`, `br_taken_count`  out  32  statistics (only with `BRANCH_STATS_EN`).

## Operation
- `BrUn` = 1 for `funct3` 110/111, else 0. It is purely combinational and independent of `is_branch`.
- Branch condition by `funct3`: 000 BrEq; 001 !BrEq; 100 BrLT; 101 !BrLT; 110 BrLT; 111 !BrLT.
- `taken` = (is_branch & cond) | is_jal | is_jalr, gated by state RUN & instr_valid.
- Target: JAL/branch = pc + imm; JALR = (rs1 + imm) & ~1. All arithmetic is modulo 2^32, with no overflow detection.
- next_pc = taken ? target : pc + 4.
- Fault cases, evaluated only in a commit cycle:
  - taken with target[1:0] != 0;
  - is_branch with `funct3` 010/011;
  - more than one of is_branch/is_jal/is_jalr high.
- FSM, state is registered:
  - BOOT: entered on `rst`. Lasts one cycle. PC holds RESET_VECTOR, `taken` = 0. Goes to RUN unconditionally, even if `stall` is high.
  - RUN: commit cycle = instr_valid & !stall. On commit with no fault, pc <= next_pc. On commit with a fault, go to HALT, trap_pc <= pc, pc holds.
  - HALT: pc frozen, `trap` = 1, `taken` = 0. Only `rst` exits.
- Bubble (instr_valid = 0) or stall: pc holds and no fault is evaluated.

## Timing
- Combinational in the same cycle: `BrUn`, `taken`, `pc_plus4`.
- Registered: `pc`, `trap`, `trap_pc`, counters. Next PC is visible 1 cycle after the commit edge.
- Reset values: pc = RESET_VECTOR, trap = 0, trap_pc = 0, counters = 0, state = BOOT. `taken` is 0 during BOOT.
- `rst` has priority over `stall` and over a fault in the same cycle.
- `stall` with a would-be fault: no trap until a cycle in which `stall` is low.
- pc = 32'hFFFF_FFFC not taken: wraps to 0 with no trap.

## Configuration
- `BRANCH_STATS_EN` defined: ports `br_count` and `br_taken_count` exist.
  - br_count increments on each committed is_branch.
  - br_taken_count increments on each committed taken branch (B-type only).
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package `branch_pkg`: funct3 localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU), FSM state encoding (BOOT, RUN, HALT), and the default RESET_VECTOR.
- One sub-module, `branch_cond`: combinational funct3/BrEq/BrLT → BrUn, cond, illegal_funct3.
- The PC register, FSM and counters stay in the top module.

## Test plan
- Reset, then release: cycle 0 pc = 0 (BOOT); next cycle pc = 0 (RUN entry); with valid non-control instructions pc = 4, then 8.
- BEQ, BrEq = 1, pc = 0x100, imm = 0x20: `taken` = 1, next pc = 0x120. Same with BrEq = 0: next pc = 0x104.
- BLTU (`funct3` 110): `BrUn` = 1. BrLT = 1, imm = -8 at pc = 0x40: next pc = 0x38.
- JALR, rs1 = 0x203, imm = 0: target 0x202 is misaligned, so trap = 1, trap_pc = faulting pc, and pc stays frozen despite further valid instructions until `rst`.
- JAL with imm = 0x10 while `stall` = 1 for 3 cycles: pc unchanged; it updates to pc + 0x10 on the first unstalled cycle.
- With `BRANCH_STATS_EN`: 5 branches, 3 taken → br_count = 5, br_taken_count = 3. A JAL leaves both unchanged.
